// File: rtl/command_issue_control.sv
// Command FIFO, CAPI tag allocation and PSL credit control between the command
// buffer arbiter and the PSL command/response interface.
module command_issue_control #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_TAGS   = 32,
  parameter int CU_ID_W    = 8,
  parameter int CMD_TYPE_W = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enabled,
  input  logic                  in_valid,
  input  logic [12:0]           in_command,
  input  logic [63:0]           in_address,
  input  logic [11:0]           in_size,
  input  logic [CU_ID_W-1:0]    in_cu_id,
  input  logic [CMD_TYPE_W-1:0] in_cmd_type,
  output logic                  arbiter_enable,
  input  logic [7:0]            ha_croom,
  output logic                  ah_cvalid,
  output logic [12:0]           ah_com,
  output logic [63:0]           ah_cea,
  output logic [11:0]           ah_csize,
  output logic [7:0]            ah_ctag,
  output logic [2:0]            ah_cabt,
  input  logic                  ha_rvalid,
  input  logic [7:0]            ha_rtag,
  input  logic [7:0]            ha_response,
  input  logic [8:0]            ha_rcredits,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_tag,
  output logic [7:0]            rsp_response,
  output logic [CU_ID_W-1:0]    rsp_cu_id,
  output logic [CMD_TYPE_W-1:0] rsp_cmd_type,
  output logic [8:0]            credits,
  output logic                  tag_error,
  output logic                  fifo_overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int META_W = CU_ID_W + CMD_TYPE_W;

  typedef struct packed {
    logic [12:0]           command;
    logic [63:0]           address;
    logic [11:0]           size;
    logic [CU_ID_W-1:0]    cu_id;
    logic [CMD_TYPE_W-1:0] cmd_type;
  } cmd_t;

  cmd_t              fifo_mem  [FIFO_DEPTH];
  logic [META_W-1:0] tag_table [NUM_TAGS];

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [8:0]        credits_q, credits_d;
  logic              enabled_q, tag_error_q, tag_error_d, overflow_q, overflow_d;

  logic                  ah_cvalid_q, rsp_valid_q;
  logic [12:0]           ah_com_q;
  logic [63:0]           ah_cea_q;
  logic [11:0]           ah_csize_q;
  logic [7:0]            ah_ctag_q, rsp_tag_q, rsp_response_q;
  logic [CU_ID_W-1:0]    rsp_cu_id_q;
  logic [CMD_TYPE_W-1:0] rsp_cmd_type_q;

  cmd_t              in_cmd, head;
  logic              empty, full, issue, push, load, tag_free, rsp_hit, rsp_known;
  logic [7:0]        free_tag;
  logic [META_W-1:0] rsp_meta;
  logic signed [9:0] issue_delta, rsp_delta, credit_sum;

  assign in_cmd = '{command: in_command, address: in_address, size: in_size,
                    cu_id: in_cu_id, cmd_type: in_cmd_type};
  assign head   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (count == '0);
  assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));

  // Two slots of margin absorb the arbiter's in-flight grant and output register.
  assign arbiter_enable = enabled && ((int'(count) + int'(in_valid)) <= FIFO_DEPTH - 2);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned.
    tag_free = 1'b0;
    free_tag = '0;
    rsp_hit  = 1'b0;
    rsp_meta = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        tag_free = 1'b1;
        free_tag = 8'(i);
      end
    end
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (ha_rtag == 8'(i)) begin
        rsp_hit  = busy_q[i];
        rsp_meta = tag_table[i];
      end
    end

    issue     = enabled && !empty && (credits_q != '0) && tag_free;
    push      = in_valid && (!full || issue);
    load      = enabled && !enabled_q;
    rsp_known = ha_rvalid && rsp_hit;

    wr_ptr_d    = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d  = overflow_q  || (in_valid && full && !issue);
    tag_error_d = tag_error_q || (ha_rvalid && !rsp_hit);

    busy_d = busy_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (issue && free_tag == 8'(i))      busy_d[i] = 1'b1;
      if (rsp_known && ha_rtag == 8'(i))   busy_d[i] = 1'b0;
    end

    issue_delta = issue     ? -10'sd1 : 10'sd0;
    rsp_delta   = rsp_known ? signed'({ha_rcredits[8], ha_rcredits}) : 10'sd0;
    credit_sum  = signed'({1'b0, credits_q}) + issue_delta + rsp_delta;
    if (load)                      credits_d = {1'b0, ha_croom};
    else if (credit_sum < 10'sd0)  credits_d = '0;
    else if (credit_sum > 10'sd255) credits_d = 9'd255;
    else                           credits_d = credit_sum[8:0];
  end

  // NOTE: storage is not reset; the pointers and busy bits decide what is ever read.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= in_cmd;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (issue && free_tag == 8'(i)) tag_table[i] <= {head.cu_id, head.cmd_type};
    end
  end

  // NOTE: non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      busy_q         <= '0;
      credits_q      <= '0;
      enabled_q      <= 1'b0;
      tag_error_q    <= 1'b0;
      overflow_q     <= 1'b0;
      ah_cvalid_q    <= 1'b0;
      ah_com_q       <= '0;
      ah_cea_q       <= '0;
      ah_csize_q     <= '0;
      ah_ctag_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_tag_q      <= '0;
      rsp_response_q <= '0;
      rsp_cu_id_q    <= '0;
      rsp_cmd_type_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      busy_q      <= busy_d;
      credits_q   <= credits_d;
      enabled_q   <= enabled;
      tag_error_q <= tag_error_d;
      overflow_q  <= overflow_d;
      ah_cvalid_q <= issue;
      if (issue) begin
        ah_com_q   <= head.command;
        ah_cea_q   <= head.address;
        ah_csize_q <= head.size;
        ah_ctag_q  <= free_tag;
      end
      rsp_valid_q <= rsp_known;
      if (rsp_known) begin
        rsp_tag_q      <= ha_rtag;
        rsp_response_q <= ha_response;
        rsp_cu_id_q    <= rsp_meta[META_W-1:CMD_TYPE_W];
        rsp_cmd_type_q <= rsp_meta[CMD_TYPE_W-1:0];
      end
    end
  end

  assign ah_cvalid     = ah_cvalid_q;
  assign ah_com        = ah_com_q;
  assign ah_cea        = ah_cea_q;
  assign ah_csize      = ah_csize_q;
  assign ah_ctag       = ah_ctag_q;
  assign ah_cabt       = 3'b000;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_response  = rsp_response_q;
  assign rsp_cu_id     = rsp_cu_id_q;
  assign rsp_cmd_type  = rsp_cmd_type_q;
  assign credits       = credits_q;
  assign tag_error     = tag_error_q;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_command_issue_control.sv
// Directed bench for command_issue_control, built with four tags so tag
// exhaustion is reachable with short stimulus.
module tb_command_issue_control;

  logic        clock = 1'b0, rst = 1'b1, enabled = 1'b0, in_valid = 1'b0;
  logic [12:0] in_command = '0;
  logic [63:0] in_address = '0;
  logic [11:0] in_size = '0;
  logic [7:0]  in_cu_id = '0;
  logic [3:0]  in_cmd_type = '0;
  logic        arbiter_enable;
  logic [7:0]  ha_croom = '0;
  logic        ah_cvalid;
  logic [12:0] ah_com;
  logic [63:0] ah_cea;
  logic [11:0] ah_csize;
  logic [7:0]  ah_ctag;
  logic [2:0]  ah_cabt;
  logic        ha_rvalid = 1'b0;
  logic [7:0]  ha_rtag = '0, ha_response = '0;
  logic [8:0]  ha_rcredits = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_tag, rsp_response, rsp_cu_id;
  logic [3:0]  rsp_cmd_type;
  logic [8:0]  credits;
  logic        tag_error, fifo_overflow;

  command_issue_control #(.FIFO_DEPTH(8), .NUM_TAGS(4), .CU_ID_W(8), .CMD_TYPE_W(4)) dut (
    .clock(clock), .rst(rst), .enabled(enabled), .in_valid(in_valid),
    .in_command(in_command), .in_address(in_address), .in_size(in_size),
    .in_cu_id(in_cu_id), .in_cmd_type(in_cmd_type), .arbiter_enable(arbiter_enable),
    .ha_croom(ha_croom), .ah_cvalid(ah_cvalid), .ah_com(ah_com), .ah_cea(ah_cea),
    .ah_csize(ah_csize), .ah_ctag(ah_ctag), .ah_cabt(ah_cabt), .ha_rvalid(ha_rvalid),
    .ha_rtag(ha_rtag), .ha_response(ha_response), .ha_rcredits(ha_rcredits),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_response(rsp_response),
    .rsp_cu_id(rsp_cu_id), .rsp_cmd_type(rsp_cmd_type), .credits(credits),
    .tag_error(tag_error), .fifo_overflow(fifo_overflow)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int n_iss;
  logic [7:0]  got_tag [32];
  logic [12:0] got_com [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_push(input logic [12:0] cmd, input logic [7:0] cu);
    in_valid    = 1'b1;
    in_command  = cmd;
    in_address  = 64'h1000 + {51'd0, cmd};
    in_size     = 12'd128;
    in_cu_id    = cu;
    in_cmd_type = cmd[3:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [7:0] t, input logic [8:0] cr);
    ha_rvalid = 1'b1; ha_rtag = t; ha_rcredits = cr; ha_response = 8'h5A;
  endtask

  task automatic record();
    if (ah_cvalid) begin
      if (n_iss < 32) begin
        got_tag[n_iss] = ah_ctag;
        got_com[n_iss] = ah_com;
      end
      n_iss++;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; enabled = 1'b0; in_valid = 1'b0; ha_rvalid = 1'b0;
    ha_rtag = '0; ha_rcredits = '0; ha_croom = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_iss = 0;
    for (int i = 0; i < 32; i++) begin
      got_tag[i] = 8'hFF;
      got_com[i] = 13'h1FFF;
    end
  endtask

  task automatic bad_rsp(input logic [7:0] t);
    reset_dut();
    enabled = 1'b1; ha_croom = 8'd4;
    drive_push(13'h040, 8'd9);
    tick(); idle(); tick(); tick();
    check("bad_pre_err", tag_error, 0);
    respond(t, 9'd5);
    tick(); ha_rvalid = 1'b0;
    check("bad_no_rsp", rsp_valid, 0);
    check("bad_err", tag_error, 1);
    check("bad_credits", credits, 3);
    tick();
    check("bad_err_sticky", tag_error, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ae1, ae2, cur;
    int pushes;

    // Reset values
    reset_dut();
    check("rst_cvalid", ah_cvalid, 0);
    check("rst_rvalid", rsp_valid, 0);
    check("rst_credits", credits, 0);
    check("rst_tag_err", tag_error, 0);
    check("rst_ovf", fifo_overflow, 0);
    check("rst_cabt", ah_cabt, 0);
    check("rst_ctag", ah_ctag, 0);
    check("rst_rsp_cu", rsp_cu_id, 0);
    check("rst_arb_en", arbiter_enable, 0);

    // Basic issue and response
    enabled = 1'b1; ha_croom = 8'd4;
    drive_push(13'h0A05, 8'd3);
    tick(); idle();
    check("basic_load", credits, 4);
    check("basic_no_early", ah_cvalid, 0);
    tick();
    check("basic_cvalid", ah_cvalid, 1);
    check("basic_ctag", ah_ctag, 0);
    check("basic_com", ah_com, 13'h0A05);
    check("basic_cea", ah_cea, 64'h1A05);
    check("basic_csize", ah_csize, 128);
    check("basic_cred_dec", credits, 3);
    tick();
    check("basic_one_cycle", ah_cvalid, 0);
    respond(8'd0, 9'd1);
    tick(); ha_rvalid = 1'b0;
    check("basic_rsp_valid", rsp_valid, 1);
    check("basic_rsp_cu", rsp_cu_id, 3);
    check("basic_rsp_type", rsp_cmd_type, 5);
    check("basic_rsp_tag", rsp_tag, 0);
    check("basic_rsp_resp", rsp_response, 8'h5A);
    check("basic_cred_ret", credits, 4);
    tick();
    check("basic_rsp_pulse", rsp_valid, 0);

    // Credit starvation
    reset_dut();
    enabled = 1'b1; ha_croom = 8'd2;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) drive_push(13'h100 + 13'(i), 8'(i)); else idle();
      tick();
      record();
    end
    check("starve_issues", n_iss, 2);
    check("starve_tag0", got_tag[0], 0);
    check("starve_tag1", got_tag[1], 1);
    check("starve_credits", credits, 0);
    check("starve_arb_en", arbiter_enable, 1);
    respond(8'd0, 9'd1);
    tick(); ha_rvalid = 1'b0;
    check("starve_rsp", rsp_valid, 1);
    check("starve_not_same", ah_cvalid, 0);
    check("starve_cred1", credits, 1);
    tick();
    check("starve_reissue", ah_cvalid, 1);
    check("starve_reuse_tag", ah_ctag, 0);
    check("starve_order", ah_com, 13'h102);
    check("starve_cred0", credits, 0);
    tick();
    check("starve_stall", ah_cvalid, 0);

    // Tag exhaustion, then simultaneous issue and response
    reset_dut();
    enabled = 1'b1; ha_croom = 8'd16;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive_push(13'h300 + 13'(i), 8'(i)); else idle();
      tick();
      record();
    end
    check("exh_issues", n_iss, 4);
    for (int i = 0; i < 4; i++) check("exh_tag", got_tag[i], i);
    check("exh_credits", credits, 12);
    respond(8'd2, 9'd0);
    tick(); ha_rvalid = 1'b0;
    check("exh_no_same_cycle", ah_cvalid, 0);
    check("exh_rsp_tag", rsp_tag, 2);
    tick();
    check("exh_next_cycle", ah_cvalid, 1);
    check("exh_tag2", ah_ctag, 2);
    check("exh_com", ah_com, 13'h304);
    check("exh_cred11", credits, 11);
    respond(8'd0, 9'd3);
    tick();
    check("both_pre_cvalid", ah_cvalid, 0);
    check("both_pre_cred", credits, 14);
    respond(8'd1, 9'd2);
    tick(); ha_rvalid = 1'b0;
    check("both_cvalid", ah_cvalid, 1);
    check("both_tag", ah_ctag, 0);
    check("both_com", ah_com, 13'h305);
    check("both_rsp_tag", rsp_tag, 1);
    check("both_credits", credits, 15);

    // Back-pressure with an arbiter that reacts two cycles late
    reset_dut();
    enabled = 1'b1; ha_croom = 8'd0;
    tick();
    ae1 = 1'b1; ae2 = 1'b1; pushes = 0;
    for (int i = 0; i < 20; i++) begin
      if (ae2) begin
        drive_push(13'h200 + 13'(pushes), 8'd1);
        pushes++;
      end else idle();
      #1;
      cur = arbiter_enable;
      ae2 = ae1; ae1 = cur;
      tick();
    end
    idle(); #1;
    check("bp_pushes", pushes, 8);
    check("bp_no_ovf", fifo_overflow, 0);
    check("bp_arb_off", arbiter_enable, 0);
    drive_push(13'h1FFE, 8'd1);
    tick(); idle();
    check("bp_forced_ovf", fifo_overflow, 1);
    enabled = 1'b0;
    tick();
    enabled = 1'b1; ha_croom = 8'd16;
    for (int i = 0; i < 24; i++) begin
      tick();
      record();
      if (ah_cvalid) respond(ah_ctag, 9'd0); else ha_rvalid = 1'b0;
    end
    ha_rvalid = 1'b0;
    check("bp_drain_count", n_iss, 8);
    for (int i = 0; i < 8; i++) check("bp_drain_com", got_com[i], 13'h200 + 13'(i));

    // Bad responses: unissued in-range tag, first out-of-range tag, far out-of-range tag
    bad_rsp(8'd3);
    bad_rsp(8'd4);
    bad_rsp(8'd40);

    // Credit saturation at both ends
    reset_dut();
    enabled = 1'b1; ha_croom = 8'd250;
    drive_push(13'h050, 8'd1);
    tick(); idle(); tick();
    check("sat_cred249", credits, 249);
    respond(8'd0, 9'd100);
    tick(); ha_rvalid = 1'b0;
    check("sat_high", credits, 255);
    drive_push(13'h051, 8'd1);
    tick(); idle(); tick();
    check("sat_issue", ah_cvalid, 1);
    check("sat_cred254", credits, 254);
    respond(8'd0, 9'h100);
    tick(); ha_rvalid = 1'b0;
    check("sat_low", credits, 0);

    // Reset mid-operation: 3 tags outstanding, 4 entries queued
    reset_dut();
    enabled = 1'b1; ha_croom = 8'd6;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) enabled = 1'b0;
      drive_push(13'h600 + 13'(i), 8'(i));
      tick();
    end
    idle();
    respond(8'd3, 9'd0);
    tick(); ha_rvalid = 1'b0;
    check("mid_pre_cred", credits, 3);
    check("mid_pre_err", tag_error, 1);
    check("mid_pre_tag", ah_ctag, 2);
    #2; rst = 1'b1; #1;
    check("mid_cvalid", ah_cvalid, 0);
    check("mid_com", ah_com, 0);
    check("mid_cea", ah_cea, 0);
    check("mid_ctag", ah_ctag, 0);
    check("mid_credits", credits, 0);
    check("mid_tag_err", tag_error, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_ovf", fifo_overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    enabled = 1'b1; ha_croom = 8'd8;
    drive_push(13'h6AA, 8'd7);
    tick(); idle(); tick();
    check("post_cvalid", ah_cvalid, 1);
    check("post_tag0", ah_ctag, 0);
    check("post_com", ah_com, 13'h6AA);
    check("post_credits", credits, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
